klotski_loader: RTL and testbench

KLOTSKI_LOADER -- requirements
Module: klotski_loader

---
 rtl/klotski_pkg.sv | 28 ++
 rtl/klotski_popcnt16.sv | 14 +
 rtl/klotski_loader.sv | 157 +++++++++++++++
 tb/tb_klotski_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/klotski_pkg.sv
// Shared types and constants for the 15-puzzle board loader.
// The optional parity check is enabled by defining KLOTSKI_PARITY_CHECK_EN.
package klotski_pkg;

    localparam int N_TILES = 16;
    localparam int BOARD_W = 64;
    localparam int TILE_W  = 4;
    localparam int INV_W   = 7;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CHECK = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_DUP    = 2'd1,
        ERR_UNSOLV = 2'd2
    } err_t;

    // Selects the already-seen tiles numbered above t; each one is an inversion against t.
    function automatic logic [N_TILES-1:0] above_mask(input logic [TILE_W-1:0] t);
        return 16'hFFFE << t;
    endfunction

endpackage

// File: rtl/klotski_popcnt16.sv
// Population count of a 16-bit vector, used to count inversions per accepted tile.
module klotski_popcnt16 (
    input  logic [15:0] vec,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(vec[i]);
        end
    end

endmodule

// File: rtl/klotski_loader.sv
// Collects 16 tiles into a packed board, rejects duplicates, and hands the board to a solver.
// Defining KLOTSKI_PARITY_CHECK_EN adds the inversion-parity solvability check.
//
// state   | meaning
// S_LOAD  | accepting tiles into slot cnt
// S_CHECK | one-cycle solvability decision
// S_START | one-cycle solver start pulse
// S_WAIT  | solver owns the board until i_solver_finished
module klotski_loader
    import klotski_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [TILE_W-1:0]  i_tile,
    output logic               o_ready,
    input  logic               i_clear,
    output logic [BOARD_W-1:0] o_klotski,
    output logic               o_start,
    input  logic               i_solver_finished,
    output logic               o_busy,
    output logic [1:0]         o_err
);

    loader_state_t      state, state_nxt;
    err_t               err, err_nxt;
    logic [3:0]         cnt;
    logic [N_TILES-1:0] seen;
    logic [BOARD_W-1:0] board;
    logic               accept;
    logic               wipe;
    logic               solvable;

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        accept    = 1'b0;
        wipe      = 1'b0;
        case (state)
            S_LOAD: begin
                if (i_clear) begin
                    wipe    = 1'b1;
                    err_nxt = ERR_NONE;
                end else if (i_valid) begin
                    if (seen[i_tile]) begin
                        wipe    = 1'b1;
                        err_nxt = ERR_DUP;
                    end else begin
                        accept  = 1'b1;
                        err_nxt = ERR_NONE;
                        if (cnt == 4'(N_TILES - 1)) begin
                            state_nxt = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (i_clear) begin
                    wipe      = 1'b1;
                    err_nxt   = ERR_NONE;
                    state_nxt = S_LOAD;
                end else if (solvable) begin
                    state_nxt = S_START;
                end else begin
                    wipe      = 1'b1;
                    err_nxt   = ERR_UNSOLV;
                    state_nxt = S_LOAD;
                end
            end
            S_START: begin
                if (i_clear) begin
                    wipe      = 1'b1;
                    err_nxt   = ERR_NONE;
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_solver_finished) begin
                    wipe      = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_LOAD;
            err   <= ERR_NONE;
            cnt   <= 4'd0;
            seen  <= '0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (wipe) begin
                cnt  <= 4'd0;
                seen <= '0;
            end else if (accept) begin
                cnt          <= cnt + 4'd1;
                seen[i_tile] <= 1'b1;
            end
        end
    end

    // Board is only touched by accepted tiles; errors and clears leave the last contents visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            board <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_TILES; k++) begin
                if (cnt == 4'(k)) begin
                    board[BOARD_W-1-TILE_W*k -: TILE_W] <= i_tile;
                end
            end
        end
    end

`ifdef KLOTSKI_PARITY_CHECK_EN
    logic [INV_W-1:0] inv;
    logic [1:0]       blank_row;
    logic [4:0]       above;

    klotski_popcnt16 u_popcnt (
        .vec   (seen & above_mask(i_tile)),
        .count (above)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inv       <= '0;
            blank_row <= 2'd0;
        end else if (wipe) begin
            inv <= '0;
        end else if (accept) begin
            if (i_tile != '0) begin
                inv <= inv + INV_W'(above);
            end else begin
                blank_row <= cnt[3:2];
            end
        end
    end

    assign solvable = inv[0] ^ blank_row[0];
`else
    assign solvable = 1'b1;
`endif

    assign o_ready   = (state == S_LOAD);
    assign o_start   = (state == S_START);
    assign o_busy    = (state == S_WAIT);
    assign o_err     = err;
    assign o_klotski = board;

endmodule

// File: tb/tb_klotski_loader.sv
// Self-checking bench for klotski_loader: directed scenarios plus randomized traffic
// compared every cycle against a board/permutation-level reference model.
module tb_klotski_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [3:0]  i_tile;
    logic        i_clear;
    logic        i_solver_finished;
    logic        o_ready;
    logic [63:0] o_klotski;
    logic        o_start;
    logic        o_busy;
    logic [1:0]  o_err;

    klotski_loader dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_valid           (i_valid),
        .i_tile            (i_tile),
        .o_ready           (o_ready),
        .i_clear           (i_clear),
        .o_klotski         (o_klotski),
        .o_start           (o_start),
        .i_solver_finished (i_solver_finished),
        .o_busy            (o_busy),
        .o_err             (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tiles gathered so far, which values are used, and the hand-off phase.
    logic [3:0] m_board[16];
    bit         m_used[16];
    int         m_cnt;
    bit         m_check, m_start, m_busy;
    logic [1:0] m_err;

    function automatic bit m_solvable();
`ifdef KLOTSKI_PARITY_CHECK_EN
        int inv = 0;
        int br  = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_board[i] == 4'd0) br = i / 4;
            for (int j = i + 1; j < 16; j++)
                if (m_board[i] != 0 && m_board[j] != 0 && m_board[i] > m_board[j]) inv++;
        end
        return ((inv + br) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [63:0] m_packed();
        logic [63:0] b = '0;
        for (int k = 0; k < 16; k++) b[63-4*k -: 4] = m_board[k];
        return b;
    endfunction

    task automatic m_forget();
        m_cnt = 0;
        for (int i = 0; i < 16; i++) m_used[i] = 1'b0;
    endtask

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) m_board[i] = 4'd0;
            m_forget();
            m_check = 0; m_start = 0; m_busy = 0; m_err = 2'd0;
        end else if (m_busy) begin
            if (i_solver_finished) begin m_busy = 0; m_forget(); end
        end else if (m_start) begin
            m_start = 0;
            if (i_clear) begin m_forget(); m_err = 2'd0; end
            else m_busy = 1;
        end else if (m_check) begin
            m_check = 0;
            if (i_clear) begin m_forget(); m_err = 2'd0; end
            else if (m_solvable()) m_start = 1;
            else begin m_forget(); m_err = 2'd2; end
        end else if (i_clear) begin
            m_forget(); m_err = 2'd0;
        end else if (i_valid) begin
            if (m_used[i_tile]) begin
                m_forget(); m_err = 2'd1;
            end else begin
                m_board[m_cnt] = i_tile;
                m_used[i_tile] = 1'b1;
                m_err = 2'd0;
                m_cnt++;
                if (m_cnt == 16) begin m_cnt = 0; m_check = 1; end
            end
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n)
            check("cmp_ready", 64'(o_ready), 64'(!m_check && !m_start && !m_busy));
        check("cmp_start",   64'(o_start),  64'(m_start));
        check("cmp_busy",    64'(o_busy),   64'(m_busy));
        check("cmp_err",     64'(o_err),    64'(m_err));
        check("cmp_klotski", o_klotski,     m_packed());
    end

    task automatic cyc(input bit v, input logic [3:0] t, input bit c, input bit f);
        i_valid = v; i_tile = t; i_clear = c; i_solver_finished = f;
        @(posedge i_clk);
        #2;
        i_valid = 0; i_clear = 0; i_solver_finished = 0;
    endtask

    task automatic feed_std(input bit swap);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] t;
            t = (k == 15) ? 4'd0 : 4'(k + 1);
            if (swap && k == 0) t = 4'd2;
            if (swap && k == 1) t = 4'd1;
            cyc(1, t, 0, 0);
        end
    endtask

    logic [3:0] perm[16];
    int         pidx;

    task automatic shuffle();
        for (int i = 0; i < 16; i++) perm[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] tmp;
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        pidx = 0;
    endtask

    initial begin
        i_rst_n = 0; i_valid = 0; i_tile = 0; i_clear = 0; i_solver_finished = 0;
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1;
        check("rst_klotski", o_klotski, 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);

        // Ordered board: start pulse lands two edges after the last handshake.
        feed_std(0);
        check("ord_no_early_start", 64'(o_start), 64'd0);
        cyc(0, 0, 0, 0);
        check("ord_start", 64'(o_start), 64'd1);
        check("ord_board", o_klotski, 64'h123456789ABCDEF0);
        cyc(0, 0, 0, 0);
        check("ord_start_one_cycle", 64'(o_start), 64'd0);
        repeat (3) cyc(0, 0, 0, 0);
        check("ord_busy", 64'(o_busy), 64'd1);
        cyc(0, 0, 0, 1);
        check("ord_ready_after_fin", 64'(o_ready), 64'd1);

        // Duplicate tile.
        cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
        check("dup_err", 64'(o_err), 64'd1);
        cyc(1, 5, 0, 0);
        check("dup_slot0", 64'(o_klotski[63:60]), 64'd5);
        check("dup_err_cleared", 64'(o_err), 64'd0);
        cyc(0, 0, 1, 0);

        // Odd permutation with blank in the bottom row.
        feed_std(1);
        cyc(0, 0, 0, 0);
`ifdef KLOTSKI_PARITY_CHECK_EN
        check("unsolv_err", 64'(o_err), 64'd2);
        check("unsolv_no_start", 64'(o_start), 64'd0);
        cyc(0, 0, 0, 0);
        check("unsolv_ready", 64'(o_ready), 64'd1);
`else
        check("noparity_start", 64'(o_start), 64'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
`endif

        // Clear with the 8th tile.
        for (int k = 1; k <= 7; k++) cyc(1, 4'(k), 0, 0);
        cyc(1, 8, 1, 0);
        check("clr_ready", 64'(o_ready), 64'd1);
        cyc(1, 9, 0, 0);
        check("clr_slot0", 64'(o_klotski[63:60]), 64'd9);
        cyc(0, 0, 1, 0);
        feed_std(0);
        cyc(0, 0, 0, 0);
        check("clr_reload_start", 64'(o_start), 64'd1);
        cyc(0, 0, 0, 0);

        // Tiles offered while the solver owns the board.
        for (int k = 0; k < 4; k++) begin
            cyc(1, 4'(k + 3), 1, 0);
            check("wait_ready", 64'(o_ready), 64'd0);
            check("wait_board", o_klotski, 64'h123456789ABCDEF0);
        end
        cyc(0, 0, 0, 1);
        check("wait_fin_ready", 64'(o_ready), 64'd1);

        // Reset after 10 tiles, then a fresh load.
        for (int k = 1; k <= 10; k++) cyc(1, 4'(k), 0, 0);
        i_rst_n = 0;
        #1;
        check("rst_mid_klotski", o_klotski, 64'd0);
        check("rst_mid_err", 64'(o_err), 64'd0);
        check("rst_mid_start", 64'(o_start), 64'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1;
        feed_std(0);
        cyc(0, 0, 0, 0);
        check("rst_reload_start", 64'(o_start), 64'd1);
        cyc(0, 0, 0, 0);
        i_rst_n = 0;
        #1;
        check("rst_wait_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1;
        repeat (3) begin
            cyc(0, 0, 0, 0);
            check("rst_wait_no_start", 64'(o_start), 64'd0);
        end

        // Randomized traffic.
        shuffle();
        for (int n = 0; n < 4000; n++) begin
            bit v, c, f;
            logic [3:0] t;
            if (o_ready && m_cnt == 0 && pidx != 0) shuffle();
            v = ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 99) < 2);
            f = m_busy ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 4) t = 4'($urandom_range(0, 15));
            else t = perm[pidx];
            if (v && !c && o_ready && t == perm[pidx]) begin
                pidx++;
                if (pidx == 16) shuffle();
            end
            cyc(v, t, c, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
